// File: rtl/synth_pkg.sv
// Shared types and constants for the MIDI-to-synth note scheduler.
package synth_pkg;

  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_CTRL     = 2'd2,
    EV_RSVD     = 2'd3
  } ev_type_t;

  localparam logic [7:0] KEY_ADDR_BASE  = 8'h00;
  localparam logic [7:0] CTRL_ADDR_BASE = 8'h80;
  localparam int         PLAY_BIT       = 7;
  localparam int         NUM_CTRL       = 16;
  localparam int         KEY_W          = 7;
  localparam int         VEL_W          = 7;
  localparam int         EV_DATA_W      = 20;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_age_search.sv
// Combinational voice-table search: oldest valid entry (modular age, lowest index on ties),
// first free entry, and the entry holding a given key.
module voice_age_search
  import synth_pkg::*;
#(
  parameter int MAX_VOICES = 8,
  parameter int AGE_W      = 8,
  localparam int IDX_W     = idx_width(MAX_VOICES)
) (
  input  logic [MAX_VOICES-1:0]            i_vld,
  input  logic [MAX_VOICES-1:0][KEY_W-1:0] i_key,
  input  logic [MAX_VOICES-1:0][AGE_W-1:0] i_stamp,
  input  logic [AGE_W-1:0]                 i_cnt,
  input  logic [KEY_W-1:0]                 i_key_q,
  output logic [IDX_W-1:0]                 o_victim_idx,
  output logic [IDX_W-1:0]                 o_free_idx,
  output logic                             o_free_found,
  output logic [IDX_W-1:0]                 o_match_idx,
  output logic                             o_match_hit
);

  logic [AGE_W-1:0] w_age;
  logic [AGE_W-1:0] w_best_age;
  logic             w_best_found;

  always_comb begin
    o_victim_idx = '0;
    o_free_idx   = '0;
    o_free_found = 1'b0;
    o_match_idx  = '0;
    o_match_hit  = 1'b0;
    w_age        = '0;
    w_best_age   = '0;
    w_best_found = 1'b0;
    for (int i = 0; i < MAX_VOICES; i++) begin
      // Modular difference keeps ordering correct across counter wrap.
      w_age = i_cnt - i_stamp[i];
      if (!i_vld[i] && !o_free_found) begin
        o_free_found = 1'b1;
        o_free_idx   = IDX_W'(i);
      end
      if (i_vld[i] && !o_match_hit && (i_key[i] == i_key_q)) begin
        o_match_hit = 1'b1;
        o_match_idx = IDX_W'(i);
      end
      if (i_vld[i] && (!w_best_found || (w_age > w_best_age))) begin
        w_best_found = 1'b1;
        w_best_age   = w_age;
        o_victim_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/synth_note_scheduler.sv
// Turns note/control events into Avalon writes, tracking held keys in a voice table.
// Build option SYNTH_VOICE_STEAL_EN: steal the oldest voice when full; otherwise drop the note-on.
module synth_note_scheduler
  import synth_pkg::*;
#(
  parameter int MAX_VOICES = 8,
  parameter int AGE_W      = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EV_VALID,
  output logic        EV_READY,
  input  logic [1:0]  EV_TYPE,
  input  logic [6:0]  EV_IDX,
  input  logic [19:0] EV_DATA,
  output logic        AVL_WRITE,
  output logic [7:0]  AVL_ADDR,
  output logic [31:0] AVL_WRITEDATA,
  output logic [4:0]  ACTIVE_VOICES,
  output logic        STEAL,
  output logic        DROP
);

  localparam int IDX_W = idx_width(MAX_VOICES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
`ifdef SYNTH_VOICE_STEAL_EN
    STEAL_OFF = 3'd5,
`endif
    WR_ON     = 3'd2,
    WR_OFF    = 3'd3,
    WR_CTRL   = 3'd4
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  ev_type_t                          r_ev_type;
  ev_type_t                          w_ev_type_in;
  logic [KEY_W-1:0]                  r_ev_idx;
  logic [EV_DATA_W-1:0]              r_ev_data;
  logic [MAX_VOICES-1:0]             r_vld;
  logic [MAX_VOICES-1:0][KEY_W-1:0]  r_key;
  logic [MAX_VOICES-1:0][AGE_W-1:0]  r_stamp;
  logic [AGE_W-1:0]                  r_stamp_cnt;
  logic [IDX_W-1:0]                  r_slot;
  logic                              r_hit;
  logic [4:0]                        r_active;
  logic [4:0]                        w_active;
  logic                              w_accept;
  logic [VEL_W-1:0]                  w_vel;
  logic [IDX_W-1:0]                  w_victim_idx;
  logic [IDX_W-1:0]                  w_free_idx;
  logic                              w_free_found;
  logic [IDX_W-1:0]                  w_match_idx;
  logic                              w_match_hit;
  logic [IDX_W-1:0]                  w_slot_sel;

  voice_age_search #(
    .MAX_VOICES (MAX_VOICES),
    .AGE_W      (AGE_W)
  ) u_search (
    .i_vld        (r_vld),
    .i_key        (r_key),
    .i_stamp      (r_stamp),
    .i_cnt        (r_stamp_cnt),
    .i_key_q      (r_ev_idx),
    .o_victim_idx (w_victim_idx),
    .o_free_idx   (w_free_idx),
    .o_free_found (w_free_found),
    .o_match_idx  (w_match_idx),
    .o_match_hit  (w_match_hit)
  );

  assign w_accept     = (r_state == IDLE) && EV_VALID;
  assign w_ev_type_in = ev_type_t'(EV_TYPE);
  assign w_vel        = r_ev_data[VEL_W-1:0];
  // With no hit and no free entry the slot is the victim, which STEAL_OFF relies on.
  assign w_slot_sel   = w_match_hit  ? w_match_idx :
                        w_free_found ? w_free_idx  : w_victim_idx;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    EV_READY      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_ADDR      = '0;
    AVL_WRITEDATA = '0;
    STEAL         = 1'b0;
    DROP          = 1'b0;
    case (r_state)
      IDLE: begin
        EV_READY = 1'b1;
        if (EV_VALID) w_state_nxt = DECODE;
      end
      DECODE: begin
        case (r_ev_type)
          EV_CTRL:     w_state_nxt = WR_CTRL;
          EV_NOTE_OFF: w_state_nxt = WR_OFF;
          EV_NOTE_ON: begin
            if (w_match_hit || w_free_found) w_state_nxt = WR_ON;
`ifdef SYNTH_VOICE_STEAL_EN
            else w_state_nxt = STEAL_OFF;
`else
            else begin
              DROP        = 1'b1;
              w_state_nxt = IDLE;
            end
`endif
          end
          default:     w_state_nxt = IDLE;
        endcase
      end
`ifdef SYNTH_VOICE_STEAL_EN
      STEAL_OFF: begin
        AVL_WRITE   = 1'b1;
        AVL_ADDR    = KEY_ADDR_BASE | {1'b0, r_key[r_slot]};
        STEAL       = 1'b1;
        w_state_nxt = WR_ON;
      end
`endif
      WR_ON: begin
        AVL_WRITE                  = 1'b1;
        AVL_ADDR                   = KEY_ADDR_BASE | {1'b0, r_ev_idx};
        AVL_WRITEDATA[PLAY_BIT]    = 1'b1;
        AVL_WRITEDATA[VEL_W-1:0]   = w_vel;
        w_state_nxt                = IDLE;
      end
      WR_OFF: begin
        AVL_WRITE                  = 1'b1;
        AVL_ADDR                   = KEY_ADDR_BASE | {1'b0, r_ev_idx};
        AVL_WRITEDATA[VEL_W-1:0]   = w_vel;
        w_state_nxt                = IDLE;
      end
      WR_CTRL: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = CTRL_ADDR_BASE | {4'h0, r_ev_idx[3:0]};
        AVL_WRITEDATA = {12'h0, r_ev_data};
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ev_type <= EV_NOTE_OFF;
      r_ev_idx  <= '0;
      r_ev_data <= '0;
    end else if (w_accept) begin
      // Velocity-0 note-on is a note-off by MIDI convention.
      r_ev_type <= ((w_ev_type_in == EV_NOTE_ON) && (EV_DATA[VEL_W-1:0] == '0)) ?
                   EV_NOTE_OFF : w_ev_type_in;
      r_ev_idx  <= EV_IDX;
      r_ev_data <= EV_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vld       <= '0;
      r_key       <= '0;
      r_stamp     <= '0;
      r_stamp_cnt <= '0;
      r_slot      <= '0;
      r_hit       <= 1'b0;
    end else begin
      case (r_state)
        DECODE: begin
          r_slot <= w_slot_sel;
          r_hit  <= w_match_hit;
        end
`ifdef SYNTH_VOICE_STEAL_EN
        STEAL_OFF: r_key[r_slot] <= r_ev_idx;
`endif
        WR_ON: begin
          r_vld[r_slot]   <= 1'b1;
          r_key[r_slot]   <= r_ev_idx;
          r_stamp[r_slot] <= r_stamp_cnt;
          r_stamp_cnt     <= r_stamp_cnt + 1'b1;
        end
        WR_OFF: begin
          if (r_hit) r_vld[r_slot] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_active = '0;
    for (int i = 0; i < MAX_VOICES; i++) begin
      w_active = w_active + 5'(r_vld[i]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_active <= '0;
    end else begin
      r_active <= w_active;
    end
  end

  assign ACTIVE_VOICES = r_active;

endmodule

// File: tb/tb_synth_note_scheduler.sv
// Scoreboard bench for synth_note_scheduler: expected writes queued at acceptance, checked on output.
module tb_synth_note_scheduler;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        EV_VALID = 1'b0;
  logic        EV_READY;
  logic [1:0]  EV_TYPE = '0;
  logic [6:0]  EV_IDX = '0;
  logic [19:0] EV_DATA = '0;
  logic        AVL_WRITE;
  logic [7:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [4:0]  ACTIVE_VOICES;
  logic        STEAL;
  logic        DROP;

  synth_note_scheduler #(.MAX_VOICES(8), .AGE_W(8)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .EV_VALID      (EV_VALID),
    .EV_READY      (EV_READY),
    .EV_TYPE       (EV_TYPE),
    .EV_IDX        (EV_IDX),
    .EV_DATA       (EV_DATA),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .ACTIVE_VOICES (ACTIVE_VOICES),
    .STEAL         (STEAL),
    .DROP          (DROP)
  );

  always #5 CLK = ~CLK;

`ifdef SYNTH_VOICE_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  localparam int M_WR   = 0;
  localparam int M_FULL = 1;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  got_steal = 0;
  int  got_drop = 0;
  int  exp_steal = 0;
  int  exp_drop = 0;
  int  n_on = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (STEAL) got_steal++;
      if (DROP) got_drop++;
      if (AVL_WRITE) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write_addr", {24'h0, AVL_ADDR}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {24'h0, AVL_ADDR}, {24'h0, mon_e.addr});
          chk("wr_data", AVL_WRITEDATA, mon_e.data);
          chk("wr_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end
    end
  end

  task automatic push_wr(input logic [7:0] addr, input logic [31:0] data, input int at);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [1:0] t, input logic [6:0] k, input logic [19:0] d,
                        output int acc);
    int n = 0;
    while (!EV_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    EV_VALID = 1'b1;
    EV_TYPE  = t;
    EV_IDX   = k;
    EV_DATA  = d;
    acc      = cyc;
    @(posedge CLK);
    #1 EV_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !EV_READY) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60) chk("done_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic ev(input logic [1:0] t, input logic [6:0] k, input logic [19:0] d,
                    input int mode, input logic [6:0] vkey);
    int acc;
    accept(t, k, d, acc);
    if (mode == M_FULL) begin
      if (STEAL_EN) begin
        push_wr({1'b0, vkey}, 32'h0, acc + 2);
        push_wr({1'b0, k}, 32'h80 | 32'(d[6:0]), acc + 3);
        n_on++;
        exp_steal++;
      end else begin
        exp_drop++;
      end
    end else if (t == 2'd2) begin
      push_wr(8'h80 | {4'h0, k[3:0]}, {12'h0, d}, acc + 2);
    end else if (t == 2'd1 && d[6:0] != 7'd0) begin
      push_wr({1'b0, k}, 32'h80 | 32'(d[6:0]), acc + 2);
      n_on++;
    end else if (t != 2'd3) begin
      push_wr({1'b0, k}, 32'(d[6:0]), acc + 2);
    end
    wait_done();
    chk("steal_count", 32'(got_steal), 32'(exp_steal));
    chk("drop_count", 32'(got_drop), 32'(exp_drop));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'h0, EV_READY}, 32'd1);
    chk({tag, "_write"}, {31'h0, AVL_WRITE}, 32'd0);
    chk({tag, "_addr"}, {24'h0, AVL_ADDR}, 32'd0);
    chk({tag, "_wdata"}, AVL_WRITEDATA, 32'd0);
    chk({tag, "_active"}, {27'h0, ACTIVE_VOICES}, 32'd0);
    chk({tag, "_steal"}, {31'h0, STEAL}, 32'd0);
    chk({tag, "_drop"}, {31'h0, DROP}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    int need;

    repeat (3) @(negedge CLK);
    chk_reset_vals("in_reset");
    RESET_N = 1'b1;
    @(negedge CLK);
    chk_reset_vals("post_reset");

    ev(2'd1, 7'd60, 20'd100, M_WR, 7'd0);
    chk("active_after_on60", {27'h0, ACTIVE_VOICES}, 32'd1);
    ev(2'd1, 7'd60, 20'd0, M_WR, 7'd0);
    chk("active_after_vel0", {27'h0, ACTIVE_VOICES}, 32'd0);
    ev(2'd2, 7'd5, 20'h01234, M_WR, 7'd0);
    chk("active_after_ctrl", {27'h0, ACTIVE_VOICES}, 32'd0);
    ev(2'd3, 7'd9, 20'h00055, M_WR, 7'd0);
    ev(2'd0, 7'd70, 20'd5, M_WR, 7'd0);
    chk("active_after_absent_off", {27'h0, ACTIVE_VOICES}, 32'd0);

    for (int i = 0; i < 8; i++) ev(2'd1, 7'(40 + i), 20'(10 + i), M_WR, 7'd0);
    chk("active_full", {27'h0, ACTIVE_VOICES}, 32'd8);
    ev(2'd1, 7'd48, 20'd30, M_FULL, 7'd40);
    chk("active_after_ninth", {27'h0, ACTIVE_VOICES}, 32'd8);
    ev(2'd1, 7'd41, 20'd31, M_WR, 7'd0);
    ev(2'd1, 7'd49, 20'd32, M_FULL, 7'd42);
    chk("active_after_retrig", {27'h0, ACTIVE_VOICES}, 32'd8);

    for (int k = 40; k < 50; k++) ev(2'd0, 7'(k), 20'd0, M_WR, 7'd0);
    chk("active_released", {27'h0, ACTIVE_VOICES}, 32'd0);

    need = (254 - n_on) & 255;
    for (int i = 0; i < need; i++) ev(2'd1, 7'd100, 20'd1, M_WR, 7'd0);
    ev(2'd0, 7'd100, 20'd0, M_WR, 7'd0);
    chk("active_pre_wrap", {27'h0, ACTIVE_VOICES}, 32'd0);
    for (int i = 0; i < 8; i++) ev(2'd1, 7'(50 + i), 20'(20 + i), M_WR, 7'd0);
    chk("active_wrap_full", {27'h0, ACTIVE_VOICES}, 32'd8);
    ev(2'd1, 7'd58, 20'd40, M_FULL, 7'd50);
    chk("active_after_wrap", {27'h0, ACTIVE_VOICES}, 32'd8);

`ifdef SYNTH_VOICE_STEAL_EN
    accept(2'd1, 7'd59, 20'd50, acc);
    push_wr(8'h33, 32'h0, acc + 2);
    exp_steal++;
    n = 0;
    while (!STEAL && n < 6) begin
      @(negedge CLK);
      n++;
    end
    chk("steal_pulse_seen", {31'h0, STEAL}, 32'd1);
`else
    accept(2'd2, 7'd3, 20'h00777, acc);
    @(negedge CLK);
    chk("decode_no_write", {31'h0, AVL_WRITE}, 32'd0);
`endif
    #2 RESET_N = 1'b0;
    #1 chk_reset_vals("mid_reset");
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (8) @(negedge CLK);
    chk("queue_empty_after_reset", 32'(exp_q.size()), 32'd0);
    chk("steal_count_final", 32'(got_steal), 32'(exp_steal));
    chk_reset_vals("after_mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synth_note_scheduler.md
Name: synth_note_scheduler

Overview:
- Sits between the MIDI event stream and the synth Avalon slave.
- Converts parsed note-on, note-off and control events into single-cycle Avalon writes to the synth's per-key play registers (addr 0x00–0x7F) and control registers (addr 0x80–0x8F).
- Enforces a polyphony limit with a voice table. When the table is full, it steals the oldest voice by writing that key's note-off before the new note-on.

Parameters:
- MAX_VOICES, 8: number of simultaneously held keys tracked (1..16).
- AGE_W, 8: width of the allocation stamp counter.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- EV_VALID  in  1  event available.
- EV_READY  out  1  event accepted when EV_VALID && EV_READY.
- EV_TYPE  in  2  0 = note-off, 1 = note-on, 2 = control, 3 = reserved.
- EV_IDX  in  7  key number, or control index (bits [3:0] used).
- EV_DATA  in  20  velocity in [6:0] for notes; control value for control events.
- AVL_WRITE  out  1  write strobe, one cycle per write.
- AVL_ADDR  out  8  Avalon address.
- AVL_WRITEDATA  out  32  Avalon write data.
- ACTIVE_VOICES  out  5  count of valid table entries.
- STEAL  out  1  one-cycle pulse when a voice is stolen.
- DROP  out  1  one-cycle pulse when a note-on is discarded.

Behaviour:
- Reset values: all outputs 0 except EV_READY = 1. Table entries invalid, stamp counter 0, state IDLE.
- Reset mid-operation aborts any pending write. No partial write is issued after RESET_N deasserts.
- Event register: captures EV_TYPE, EV_IDX and EV_DATA on acceptance.
  - A note-on with velocity 0 is recoded as a note-off.
  - Type 3 is consumed and produces no write.
- FSM states and transitions:
  - IDLE: EV_READY = 1. On accept, go to DECODE.
  - DECODE: lookup only, no outputs. Control event goes to WR_CTRL. Note-off goes to WR_OFF. Note-on routing:
    - key already in table (retrigger): WR_ON, stamp refreshed;
    - free entry exists: WR_ON, lowest-index free entry allocated;
    - table full: STEAL_OFF.
  - STEAL_OFF: AVL_WRITE = 1, AVL_ADDR = {1'b0, victim key}, AVL_WRITEDATA = 0. STEAL pulses. Victim entry is rewritten with the new key. Go to WR_ON.
  - WR_ON: AVL_WRITE = 1, AVL_ADDR = {1'b0, key}, AVL_WRITEDATA = {24'h0, 1'b1, vel[6:0]}. Stamp counter increments. Go to IDLE.
  - WR_OFF: AVL_WRITE = 1, AVL_ADDR = {1'b0, key}, AVL_WRITEDATA = {24'h0, 1'b0, vel[6:0]}.
    - Matching entry is invalidated.
    - A key absent from the table is still written, with no table change.
    - Go to IDLE.
  - WR_CTRL: AVL_WRITE = 1, AVL_ADDR = {4'h8, idx[3:0]}, AVL_WRITEDATA = {12'h0, EV_DATA}. Go to IDLE.
- Latency, with acceptance at cycle 0:
  - the write occurs at cycle 2;
  - a stolen note-off occurs at cycle 2 and its note-on at cycle 3;
  - EV_READY reasserts the cycle after the last write.
- Age arithmetic: age = counter − stamp, computed modulo 2^AGE_W.
  - The victim is the valid entry with the largest age.
  - Ties resolve to the lowest index.
  - Wrap-around is correct while fewer than 2^AGE_W allocations separate the oldest and newest entries.
- ACTIVE_VOICES updates in the cycle after the table change. It never exceeds MAX_VOICES.
- Simultaneous events cannot occur: one event is in flight at a time. EV_VALID is ignored outside IDLE.

Optional Feature:
- Macro: SYNTH_VOICE_STEAL_EN.
- Defined: stealing behaves as described above.
- Undefined: a note-on to a full table, for a key not already held, goes DECODE → IDLE. The event is consumed, DROP pulses in that DECODE cycle, and no Avalon write is issued. STEAL is tied to 0 and the STEAL_OFF state is absent.

Decomposition:
- Shared package synth_pkg holds:
  - enum ev_type_t (EV_NOTE_OFF, EV_NOTE_ON, EV_CTRL, EV_RSVD);
  - constants KEY_ADDR_BASE = 8'h00, CTRL_ADDR_BASE = 8'h80, PLAY_BIT = 7, NUM_CTRL = 16.
- Sub-module voice_age_search: combinational search over the table returning the victim index, the first free index and the key-match index/hit. Parameterised by MAX_VOICES and AGE_W.

Test Plan:
- Note-on key 60, velocity 100 → exactly one write, addr 0x3C, data 0x000000E4, at cycle 2; ACTIVE_VOICES = 1.
- Note-on key 60 with velocity 0 → write addr 0x3C, data 0x00000000; ACTIVE_VOICES returns to 0.
- Control idx 5, data 0x01234 → write addr 0x85, data 0x00001234; table unchanged.
- Nine note-ons on keys 40–48 (MAX_VOICES = 8):
  - 9th event: STEAL pulse, write addr 0x28 data 0 at cycle 2, then addr 0x30 data 0x80|vel at cycle 3; ACTIVE_VOICES stays 8.
  - With the macro undefined: DROP pulses and there is no write.
- Retrigger key 41 with the table full, then a new note-on → the victim is key 42, not 41.
- Force the stamp counter across wrap (preload to 0xFE), then fill and steal → the oldest-allocated key is stolen. Assert RESET_N low during STEAL_OFF → no WR_ON write follows, all outputs at reset values.
